// File: rtl/dnn_argmax.sv
// Sequential argmax over a snapshot of ROWS signed scores. Reports the winning
// index, the winning score and the best-minus-second-best margin with a one-cycle done pulse.
module dnn_argmax #(
  parameter int ROWS   = 10,
  parameter int DATA_W = 9,
  parameter int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ROWS*DATA_W-1:0]   score_vector,
  input  logic                     start,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         class_idx,
  output logic signed [DATA_W-1:0] max_score,
  output logic [DATA_W:0]          margin,
  output logic [1:0]               state_dbg
);

  // Handshake: a request is taken on a rising edge where start && ready; start
  // at any other time is dropped, and done is a single-cycle pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]         LAST    = IDX_W'(ROWS - 1);

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] snap_q [ROWS];
  logic signed [DATA_W-1:0] best_q, second_q, best_d, second_d, x;
  logic signed [DATA_W-1:0] fin_best, fin_second, elem0;
  logic [IDX_W-1:0]         idx_q, idx_d, ptr_q, fin_idx;
  logic [DATA_W:0]          fin_margin;
  logic                     accept, enter_done;

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q == SCAN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

  assign accept     = (state_q == IDLE) && start;
  assign enter_done = (state_d == DONE) && (state_q != DONE);
  assign elem0      = score_vector[DATA_W-1:0];
  assign x          = snap_q[ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (ROWS == 1) ? DONE : SCAN;
      SCAN:    if (ptr_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One compare step of the scan; strict '>' keeps the lowest index on ties.
  always_comb begin
    best_d   = best_q;
    second_d = second_q;
    idx_d    = idx_q;
    if (x > best_q) begin
      second_d = best_q;
      best_d   = x;
      idx_d    = ptr_q;
    end else if (x > second_q) begin
      second_d = x;
    end
  end

  // Final result: from the last scan step, or straight from element 0 when
  // a single-row configuration jumps from IDLE to DONE.
  always_comb begin
    if (state_q == SCAN) begin
      fin_best   = best_d;
      fin_second = second_d;
      fin_idx    = idx_d;
    end else begin
      fin_best   = elem0;
      fin_second = MIN_VAL;
      fin_idx    = '0;
    end
    fin_margin = {fin_best[DATA_W-1], fin_best} - {fin_second[DATA_W-1], fin_second};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) snap_q[i] <= '0;
      best_q    <= '0;
      second_q  <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      class_idx <= '0;
      max_score <= '0;
      margin    <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < ROWS; i++) snap_q[i] <= score_vector[i*DATA_W +: DATA_W];
        best_q   <= elem0;
        second_q <= MIN_VAL;
        idx_q    <= '0;
        ptr_q    <= IDX_W'(1);
      end else if (state_q == SCAN) begin
        best_q   <= best_d;
        second_q <= second_d;
        idx_q    <= idx_d;
        ptr_q    <= ptr_q + 1'b1;
      end
      if (enter_done) begin
        class_idx <= fin_idx;
        max_score <= fin_best;
        margin    <= fin_margin;
      end
    end
  end

endmodule

// File: tb/tb_dnn_argmax.sv
// Self-checking bench for dnn_argmax: table of directed vectors, random vectors
// against a reference model, and hand-written multi-cycle sequences.
module tb_dnn_argmax;
  localparam int ROWS   = 10;
  localparam int DATA_W = 9;
  localparam int IDX_W  = 4;
  localparam int VW     = ROWS * DATA_W;

  typedef struct {
    logic [VW-1:0] vec;
    int            e_idx;
    int            e_max;
    int            e_mg;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [VW-1:0]            score_vector;
  logic                     start;
  logic                     ready, busy, done;
  logic [IDX_W-1:0]         class_idx;
  logic signed [DATA_W-1:0] max_score;
  logic [DATA_W:0]          margin;
  logic [1:0]               state_dbg;

  int total = 0;
  int bad   = 0;

  dnn_argmax #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .score_vector(score_vector), .start(start),
    .ready(ready), .busy(busy), .done(done), .class_idx(class_idx),
    .max_score(max_score), .margin(margin), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(input int s[ROWS]);
    logic [VW-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*DATA_W +: DATA_W] = DATA_W'(s[i]);
    return v;
  endfunction

  // Reference: max is the first occurrence of the largest value; second-best
  // is the largest of all remaining elements.
  function automatic void model(input logic [VW-1:0] v, output int idx, output int mx, output int mg);
    int s[ROWS];
    int sec;
    logic signed [DATA_W-1:0] e;
    for (int i = 0; i < ROWS; i++) begin
      e    = v[i*DATA_W +: DATA_W];
      s[i] = int'(e);
    end
    idx = 0;
    for (int i = 1; i < ROWS; i++) if (s[i] > s[idx]) idx = i;
    mx  = s[idx];
    sec = -(1 << (DATA_W - 1));
    for (int i = 0; i < ROWS; i++) if (i != idx && s[i] > sec) sec = s[i];
    mg = mx - sec;
  endfunction

  task automatic check_outputs(input string tag, input int e_idx, input int e_max, input int e_mg);
    check({tag, " class_idx"}, int'(class_idx), e_idx);
    check({tag, " max_score"}, int'(max_score), e_max);
    check({tag, " margin"},    int'(margin),    e_mg);
  endtask

  // Start one classification, verify busy length and done latency, return at
  // the negedge where done is high (or after the bound expires).
  task automatic run_vec(input logic [VW-1:0] vec, input string tag, input bit chk_lat);
    int busy_cnt;
    int lat;
    @(negedge clk);
    score_vector = vec;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    score_vector = VW'($urandom());
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (lat < 0) check({tag, " done timeout"}, 0, 1);
    if (chk_lat) begin
      check({tag, " done latency"}, lat, ROWS - 1);
      check({tag, " busy cycles"}, busy_cnt, ROWS - 1);
    end
  endtask

  vec_t tbl[5];
  int   t[ROWS];
  int   m_idx, m_max, m_mg;
  int   done_cnt, d1, d2, o_idx, o_max, o_mg;
  logic [VW-1:0] va, vb;

  initial begin
    rst = 1'b0;
    start = 1'b0;
    score_vector = '0;

    t = '{3, -7, 12, 5, 0, -256, 40, 1, 39, -1};
    tbl[0] = '{pack(t), 6, 40, 1};
    t = '{255, -256, 255, -256, -256, -256, -256, -256, -256, -256};
    tbl[1] = '{pack(t), 0, 255, 0};
    t = '{-256, -256, -256, -256, -256, -256, -256, -256, -256, -256};
    tbl[2] = '{pack(t), 0, -256, 0};
    t = '{255, -256, -256, -256, -256, -256, -256, -256, -256, -256};
    tbl[3] = '{pack(t), 0, 255, 511};
    t = '{-5, -9, -3, -3, -100, -4, -3, -200, -6, -7};
    tbl[4] = '{pack(t), 2, -3, 0};

    // Reset asserted mid-cycle takes effect immediately.
    #3 rst = 1'b1;
    #1;
    check("rst ready", int'(ready), 1);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check_outputs("rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle ready", int'(ready), 1);
    check("idle done", int'(done), 0);
    check_outputs("idle", 0, 0, 0);

    foreach (tbl[i]) begin
      run_vec(tbl[i].vec, $sformatf("tbl%0d", i), 1'b1);
      check_outputs($sformatf("tbl%0d", i), tbl[i].e_idx, tbl[i].e_max, tbl[i].e_mg);
      @(negedge clk);
      check($sformatf("tbl%0d done pulse", i), int'(done), 0);
      check($sformatf("tbl%0d ready back", i), int'(ready), 1);
    end

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < ROWS; i++)
        t[i] = (r % 3 == 0) ? $urandom_range(0, 4) - 2 : $urandom_range(0, 511) - 256;
      va = pack(t);
      model(va, m_idx, m_max, m_mg);
      run_vec(va, $sformatf("rnd%0d", r), 1'b0);
      check_outputs($sformatf("rnd%0d", r), m_idx, m_max, m_mg);
    end

    // Start pulsed during the scan with a new vector: only the snapshot counts.
    t = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
    va = pack(t);
    t = '{200, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vb = pack(t);
    @(negedge clk);
    score_vector = va;
    start = 1'b1;
    @(negedge clk);
    score_vector = vb;
    repeat (3) @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check_outputs("snap", 9, 100, 91);
      end
    end
    check("snap done count", done_cnt, 1);

    // Reset four cycles into a scan aborts it.
    @(negedge clk);
    score_vector = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort ready", int'(ready), 1);
    check("abort busy", int'(busy), 0);
    check_outputs("abort", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    check_outputs("abort hold", 0, 0, 0);
    run_vec(tbl[0].vec, "after abort", 1'b1);
    check_outputs("after abort", 6, 40, 1);

    // Start held high over two vectors: accepted only in IDLE.
    @(negedge clk);
    score_vector = va;
    start = 1'b1;
    @(negedge clk);
    score_vector = vb;
    d1 = -1;
    d2 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done && d1 < 0) begin
        d1 = n;
        o_idx = int'(class_idx); o_max = int'(max_score); o_mg = int'(margin);
      end else if (done) begin
        d2 = n;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    check("b2b first done", d1, ROWS - 1);
    check("b2b spacing", d2 - d1, ROWS + 1);
    check("b2b first idx", o_idx, 9);
    check("b2b first max", o_max, 100);
    check("b2b first margin", o_mg, 91);
    check_outputs("b2b second", 0, 200, 200);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
